pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameters SHALL be declared as follows (name, default, meaning):
- D, 12: program-counter width.
- DEPTH, 4: return-stack entries, minimum 2.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- Start, in, 1: synchronous restart.
- Stall, in, 1: hold the PC this cycle.
- Done, in, 1: halt request.
- Branch, in, 1: jump enable.
- BrMode, in, 1: 0 = absolute, 1 = relative.
- target, in, D: absolute address, or two's-complement offset when BrMode=1.
- Call, in, 1: push the return address, then jump absolute.
- Ret, in, 1: pop the return address into the PC.
- prog_ctr, out, D: current PC.
- halted, out, 1: PC frozen after Done.
- stack_cnt, out, $clog2(DEPTH+1): current stack occupancy.
- stack_ovf, out, 1: sticky overflow flag.
- stack_unf, out, 1: sticky underflow flag.

Function
REQ-003 The next PC SHALL be selected in this priority order, one rule per cycle: Start > halted > Done > Stall > Ret > Call > Branch > increment.
REQ-004 Start SHALL produce, on the next edge: prog_ctr=0, halted=0, stack_cnt=0, stack_ovf=0, stack_unf=0.
REQ-005 Done SHALL hold prog_ctr and set halted on the next edge.
REQ-006 While halted=1, all inputs except Start and rst_n SHALL be ignored and the stack SHALL be frozen.
REQ-007 Stall SHALL hold prog_ctr and the stack, and SHALL drop Call, Ret and Branch for that cycle.
REQ-008 Increment SHALL be prog_ctr+1 modulo 2^D; 2^D-1 wraps to 0.
REQ-009 An absolute branch SHALL load target; target=0 is a legal jump to address 0, not a fall-through.
REQ-010 A relative branch SHALL load prog_ctr + sign-extended target, modulo 2^D, with no wrap flag.
REQ-011 Call SHALL push prog_ctr+1 (wrapped) and load target, always absolute regardless of BrMode.
REQ-012 Call with stack_cnt=DEPTH SHALL drop the push, set stack_ovf, and still jump.
REQ-013 Ret with stack_cnt>0 SHALL load the top entry and decrement stack_cnt, with zero-cycle latency: the popped value appears on prog_ctr after the same edge.
REQ-014 Ret with stack_cnt=0 SHALL set stack_unf and increment the PC.
REQ-015 Call and Ret asserted in the same cycle SHALL execute the Ret only, and the Call is discarded.
REQ-016 Branch asserted together with Call or Ret SHALL be ignored.
REQ-017 stack_ovf and stack_unf SHALL clear only on rst_n or Start.

Reset
REQ-018 Asserting rst_n low SHALL immediately force: prog_ctr=0, halted=0, stack_cnt=0, stack_ovf=0, stack_unf=0; stack contents are don't-care.
REQ-019 Reset asserted mid-operation SHALL abort any pending Call, Ret or Done.
REQ-020 The first update after rst_n deassertion SHALL occur on the second rising edge after release.

Configuration
REQ-021 With macro PC_CALL_STACK_EN defined, the return stack SHALL be present as specified above.
REQ-022 With PC_CALL_STACK_EN undefined, the following SHALL hold:
- No stack storage is built.
- Call acts as an absolute Branch with no push.
- Ret acts as a plain increment.
- stack_cnt, stack_ovf and stack_unf are tied to 0.
- All ports remain present.

Structure
REQ-023 Package pc_pkg SHALL hold:
- typedef enum br_mode_e {BR_ABS, BR_REL};
- the default D and DEPTH constants.
REQ-024 The return stack SHALL be a sub-module, pc_ret_stack, with a push/pop/data/count interface that reports full and empty; pc_ctrl owns the overflow/underflow policy.

Verification
REQ-025 Reset, then 5 free-running cycles -> prog_ctr 0,1,2,3,4,5.
REQ-026 prog_ctr=10, Branch with BrMode=1 and target=-3 -> prog_ctr=7; at 2^D-1 with no branch -> prog_ctr=0.
REQ-027 Call to target 0x100 from PC 0x020, then Ret -> prog_ctr 0x100, then 0x021, with stack_cnt 1 then 0.
REQ-028 DEPTH+1 nested Calls -> stack_ovf=1 and stack_cnt=DEPTH; DEPTH+1 Rets -> the last Ret increments the PC and sets stack_unf=1.
REQ-029 Done in the same cycle as Branch -> PC held and halted=1; later Branch or Stall has no effect; Start -> prog_ctr=0 and halted=0.
REQ-030 Stall together with Call -> no push, PC held; rst_n pulsed mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter controller.
package pc_pkg;

    typedef enum logic {
        BR_ABS = 1'b0,
        BR_REL = 1'b1
    } br_mode_e;

    localparam int PC_D_DEF     = 12;
    localparam int PC_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; top entry is read combinationally so a pop lands
// on the PC at the same edge. Overflow/underflow policy lives in the caller.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int D     = PC_D_DEF,
    parameter int DEPTH = PC_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [D-1:0]  data_i,
    output logic [D-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [D-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;
    assign wr_idx  = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - 1'b1);
    assign data_o  = mem_q[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (clr_i)   cnt_q <= '0;
        else if (do_push) cnt_q <= cnt_q + 1'b1;
        else if (do_pop)  cnt_q <= cnt_q - 1'b1;
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller with branch, call/return and halt.
// Define PC_CALL_STACK_EN to build the return stack; otherwise Call is a plain
// absolute jump, Ret a plain increment, and the stack outputs read 0.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int D     = PC_D_DEF,
    parameter int DEPTH = PC_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Start,
    input  logic                       Stall,
    input  logic                       Done,
    input  logic                       Branch,
    input  logic                       BrMode,
    input  logic [D-1:0]               target,
    input  logic                       Call,
    input  logic                       Ret,
    output logic [D-1:0]               prog_ctr,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] stack_cnt,
    output logic                       stack_ovf,
    output logic                       stack_unf
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [D-1:0] pc_q, pc_d;
    logic         halted_q, halted_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         run_q;
    logic         push, pop, clr;
    logic         stk_full, stk_empty;
    logic [D-1:0] stk_top;
    logic [D-1:0] pc_inc;

    assign pc_inc = pc_q + 1'b1;

`ifdef PC_CALL_STACK_EN
    pc_ret_stack #(.D(D), .DEPTH(DEPTH), .CW(CW)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .data_o  (stk_top),
        .count_o (stack_cnt),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_top   = '0;
    assign stack_cnt = '0;
`endif

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        // The first edge after reset release only arms the controller.
        if (!run_q) begin
            pc_d = pc_q;
        end else if (Start) begin
            pc_d     = '0;
            halted_d = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            clr      = 1'b1;
        end else if (halted_q) begin
            pc_d = pc_q;
        end else if (Done) begin
            halted_d = 1'b1;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (Ret) begin
`ifdef PC_CALL_STACK_EN
            if (!stk_empty) begin
                pc_d = stk_top;
                pop  = 1'b1;
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
`else
            pc_d = pc_inc;
`endif
        end else if (Call) begin
`ifdef PC_CALL_STACK_EN
            if (stk_full) ovf_d = 1'b1;
            else          push  = 1'b1;
`endif
            pc_d = target;
        end else if (Branch) begin
            pc_d = (br_mode_e'(BrMode) == BR_REL) ? pc_q + target : target;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            run_q    <= 1'b1;
        end
    end

    assign prog_ctr  = pc_q;
    assign halted    = halted_q;
`ifdef PC_CALL_STACK_EN
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_ctrl;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int M     = 1 << D;
`ifdef PC_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       Start, Stall, Done, Branch, BrMode, Call, Ret;
    logic [D-1:0]               target;
    logic [D-1:0]               prog_ctr;
    logic                       halted;
    logic [$clog2(DEPTH+1)-1:0] stack_cnt;
    logic                       stack_ovf, stack_unf;

    pc_ctrl #(.D(D), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Stall(Stall), .Done(Done),
        .Branch(Branch), .BrMode(BrMode), .target(target), .Call(Call), .Ret(Ret),
        .prog_ctr(prog_ctr), .halted(halted), .stack_cnt(stack_cnt),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_pc, m_halt, m_ovf, m_unf, m_arm;
    int m_stk[$];

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_arm = 0;
        m_stk.delete();
    endtask

    task automatic m_step(input bit st, sl, dn, br, bm, input int tg, input bit cl, rt);
        if (!m_arm) m_arm = 1;
        else if (st) begin
            m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (m_halt) begin
        end else if (dn) m_halt = 1;
        else if (sl) begin
        end else if (rt) begin
            if (STACK_EN && m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                if (STACK_EN) m_unf = 1;
                m_pc = (m_pc + 1) % M;
            end
        end else if (cl) begin
            if (STACK_EN) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back((m_pc + 1) % M);
            end
            m_pc = tg;
        end else if (br) m_pc = bm ? (m_pc + tg) % M : tg;
        else m_pc = (m_pc + 1) % M;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},  int'(prog_ctr),  m_pc);
        check({tag, ".hlt"}, int'(halted),    m_halt);
        check({tag, ".cnt"}, int'(stack_cnt), m_stk.size());
        check({tag, ".ovf"}, int'(stack_ovf), m_ovf);
        check({tag, ".unf"}, int'(stack_unf), m_unf);
    endtask

    // Called at a falling edge: apply inputs, advance model, check at next fall.
    task automatic cyc(input string tag, input bit st, sl, dn, br, bm,
                       input logic [D-1:0] tg, input bit cl, rt);
        Start = st; Stall = sl; Done = dn; Branch = br; BrMode = bm;
        target = tg; Call = cl; Ret = rt;
        m_step(st, sl, dn, br, bm, int'(tg), cl, rt);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        Start = 0; Stall = 0; Done = 0; Branch = 0; BrMode = 0;
        target = '0; Call = 0; Ret = 0;
        m_reset();
        #3;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Arm edge, then five increments
        for (int i = 0; i < 6; i++) idle("free");
        check("free5", int'(prog_ctr), 5);

        // Relative branch backwards and PC wrap
        cyc("br_abs10", 0, 0, 0, 1, 0, 12'd10, 0, 0);
        cyc("br_rel-3", 0, 0, 0, 1, 1, 12'hFFD, 0, 0);
        check("rel7", int'(prog_ctr), 7);
        cyc("br_top", 0, 0, 0, 1, 0, 12'hFFF, 0, 0);
        idle("wrap");
        check("wrap0", int'(prog_ctr), 0);
        cyc("br_zero", 0, 0, 0, 1, 0, 12'h000, 0, 0);

        // Call / Ret round trip
        cyc("to20", 0, 0, 0, 1, 0, 12'h020, 0, 0);
        cyc("call", 0, 0, 0, 1, 1, 12'h100, 1, 0);
        check("call100", int'(prog_ctr), 12'h100);
        cyc("ret", 0, 0, 0, 0, 0, '0, 0, 1);
        cyc("callret", 0, 0, 0, 1, 0, 12'h300, 1, 1);

        // Overflow then underflow
        for (int i = 0; i <= DEPTH; i++) cyc("nest", 0, 0, 0, 0, 0, 12'(40 * i + 3), 1, 0);
        for (int i = 0; i <= DEPTH; i++) cyc("unnest", 0, 0, 0, 0, 0, '0, 0, 1);

        // Halt and restart
        cyc("done_br", 0, 0, 1, 1, 0, 12'h555, 0, 0);
        check("halted", int'(halted), 1);
        cyc("h_br", 0, 0, 0, 1, 0, 12'h123, 1, 0);
        cyc("h_stall", 0, 1, 0, 0, 0, '0, 0, 1);
        idle("h_idle");
        cyc("start", 1, 0, 0, 1, 0, 12'h777, 0, 0);
        check("start_pc", int'(prog_ctr), 0);
        check("start_h", int'(halted), 0);

        // Stall with Call, then async reset mid-stall
        cyc("to50", 0, 0, 0, 1, 0, 12'h050, 0, 0);
        cyc("stall_call", 0, 1, 0, 0, 0, 12'h200, 1, 0);
        Stall = 1'b1; Call = 1'b1; target = 12'h222;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("arst_pc", int'(prog_ctr), 0);
        check_all("arst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle("arm");
        idle("post_rst");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1,
                12'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
